// File: rtl/wb_ram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_ram_arbiter_if
// Purpose  : Bundles the two Wishbone master ports and the BRAM port of
//            wb_ram_arbiter.
// Revision : 1.0  initial release
// ============================================================================
interface wb_ram_arbiter_if #(
    parameter int ADDR_W = 16
);
    logic              m0_cyc_i;
    logic              m0_stb_i;
    logic              m0_we_i;
    logic [3:0]        m0_sel_i;
    logic [31:0]       m0_adr_i;
    logic [31:0]       m0_dat_i;
    logic [31:0]       m0_dat_o;
    logic              m0_ack_o;

    logic              m1_cyc_i;
    logic              m1_stb_i;
    logic              m1_we_i;
    logic [3:0]        m1_sel_i;
    logic [31:0]       m1_adr_i;
    logic [31:0]       m1_dat_i;
    logic [31:0]       m1_dat_o;
    logic              m1_ack_o;

    logic [3:0]        ram_wea;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_din;
    logic [31:0]       ram_dout;

    logic [1:0]        gnt_o;

    modport slave (
        input  m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i,
        output m0_dat_o, m0_ack_o,
        input  m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i,
        output m1_dat_o, m1_ack_o,
        output ram_wea, ram_addr, ram_din,
        input  ram_dout,
        output gnt_o
    );

    modport master (
        output m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i,
        input  m0_dat_o, m0_ack_o,
        output m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i,
        input  m1_dat_o, m1_ack_o,
        input  ram_wea, ram_addr, ram_din,
        output ram_dout,
        input  gnt_o
    );
endinterface
`default_nettype wire

// File: rtl/wb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_ram_arbiter
// Purpose  : Two-master Wishbone arbiter/sequencer driving one single-port
//            BRAM. Define WB_ARB_RR_EN for round-robin ties, else m0 priority.
// Revision : 1.0  initial release
// ============================================================================
module wb_ram_arbiter #(
    parameter int ADDR_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    wb_ram_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_ACK    = 2'd3
    } state_t;

    localparam logic [1:0] c_wait_init = 2'(RD_LAT - 1);
    localparam bit         c_single    = (RD_LAT <= 1);

    state_t            r_state, w_state_nxt;
    logic [1:0]        r_gnt,   w_gnt_nxt;
    logic              r_we,    w_we_nxt;
    logic [3:0]        r_wea,   w_wea_nxt;
    logic [ADDR_W-1:0] r_addr,  w_addr_nxt;
    logic [31:0]       r_din,   w_din_nxt;
    logic [1:0]        r_cnt,   w_cnt_nxt;
    logic              r_last,  w_last_nxt;   // 0 = m0, 1 = m1

    logic w_req0, w_req1, w_pick1, w_cyc_gnt, w_ack0, w_ack1;

    assign w_req0    = bus.m0_cyc_i & bus.m0_stb_i;
    assign w_req1    = bus.m1_cyc_i & bus.m1_stb_i;
    // Only cyc of the granted master keeps a transfer alive; stb may drop.
    assign w_cyc_gnt = (r_gnt[0] & bus.m0_cyc_i) | (r_gnt[1] & bus.m1_cyc_i);

`ifdef WB_ARB_RR_EN
    assign w_pick1 = w_req1 & (~w_req0 | ~r_last);
`else
    assign w_pick1 = w_req1 & ~w_req0;
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_gnt  <= 2'b00;
            r_we   <= 1'b0;
            r_wea  <= 4'b0000;
            r_addr <= '0;
            r_din  <= 32'h0;
            r_cnt  <= 2'd0;
            r_last <= 1'b1;
        end else begin
            r_gnt  <= w_gnt_nxt;
            r_we   <= w_we_nxt;
            r_wea  <= w_wea_nxt;
            r_addr <= w_addr_nxt;
            r_din  <= w_din_nxt;
            r_cnt  <= w_cnt_nxt;
            r_last <= w_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_we_nxt    = r_we;
        w_wea_nxt   = r_wea;
        w_addr_nxt  = r_addr;
        w_din_nxt   = r_din;
        w_cnt_nxt   = r_cnt;
        w_last_nxt  = r_last;
        case (r_state)
            S_IDLE: begin
                w_gnt_nxt = 2'b00;
                if (w_req0 || w_req1) begin
                    w_state_nxt = S_ACCESS;
                    if (w_pick1) begin
                        w_gnt_nxt  = 2'b10;
                        w_we_nxt   = bus.m1_we_i;
                        w_addr_nxt = bus.m1_adr_i[ADDR_W+1:2];
                        w_din_nxt  = bus.m1_dat_i;
                        w_wea_nxt  = bus.m1_we_i ? bus.m1_sel_i : 4'b0000;
                    end else begin
                        w_gnt_nxt  = 2'b01;
                        w_we_nxt   = bus.m0_we_i;
                        w_addr_nxt = bus.m0_adr_i[ADDR_W+1:2];
                        w_din_nxt  = bus.m0_dat_i;
                        w_wea_nxt  = bus.m0_we_i ? bus.m0_sel_i : 4'b0000;
                    end
                end
            end
            S_ACCESS: begin
                w_wea_nxt = 4'b0000;
                if (!w_cyc_gnt) begin
                    w_state_nxt = S_IDLE;
                    w_gnt_nxt   = 2'b00;
                end else if (r_we || c_single) begin
                    w_state_nxt = S_ACK;
                end else begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = c_wait_init;
                end
            end
            S_WAIT: begin
                if (!w_cyc_gnt) begin
                    w_state_nxt = S_IDLE;
                    w_gnt_nxt   = 2'b00;
                end else if (r_cnt <= 2'd1) begin
                    w_state_nxt = S_ACK;
                end else begin
                    w_cnt_nxt = r_cnt - 2'd1;
                end
            end
            S_ACK: begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = 2'b00;
                if (w_cyc_gnt) begin
                    w_last_nxt = r_gnt[1];
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = 2'b00;
            end
        endcase
    end

    // Write strobes are masked combinationally so an abort in ACCESS never writes.
    assign w_ack0 = (r_state == S_ACK) & r_gnt[0] & bus.m0_cyc_i;
    assign w_ack1 = (r_state == S_ACK) & r_gnt[1] & bus.m1_cyc_i;

    assign bus.ram_wea  = ((r_state == S_ACCESS) && w_cyc_gnt) ? r_wea : 4'b0000;
    assign bus.ram_addr = r_addr;
    assign bus.ram_din  = r_din;
    assign bus.gnt_o    = r_gnt;
    assign bus.m0_ack_o = w_ack0;
    assign bus.m1_ack_o = w_ack1;
    assign bus.m0_dat_o = (w_ack0 && !r_we) ? bus.ram_dout : 32'h0;
    assign bus.m1_dat_o = (w_ack1 && !r_we) ? bus.ram_dout : 32'h0;

`ifdef WB_ARB_RR_EN
    logic w_unused;
    assign w_unused = ^{bus.m0_adr_i, bus.m1_adr_i};
`else
    logic w_unused;
    assign w_unused = ^{bus.m0_adr_i, bus.m1_adr_i, r_last};
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_ram_arbiter
// Purpose  : Self-checking bench for wb_ram_arbiter with RD_LAT=1 and RD_LAT=3
//            instances, each behind a behavioural BRAM.
// Revision : 1.0  initial release
// ============================================================================
module tb_wb_ram_arbiter;

    localparam int c_addr_w = 16;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    typedef struct {
        logic        who;
        logic [31:0] dat;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model[int];

    wb_ram_arbiter_if #(.ADDR_W(c_addr_w)) bus1();
    wb_ram_arbiter_if #(.ADDR_W(c_addr_w)) bus3();

    wb_ram_arbiter #(.ADDR_W(c_addr_w), .RD_LAT(1)) u_dut1 (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus1.slave)
    );

    wb_ram_arbiter #(.ADDR_W(c_addr_w), .RD_LAT(3)) u_dut3 (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural BRAMs: read-first, RD_LAT register stages on the read path.
    logic [31:0] mem1 [0:65535];
    logic [31:0] mem3 [0:65535];
    logic [31:0] rd1, rd3a, rd3b, rd3c;

    always @(posedge clk) begin
        rd1 <= mem1[bus1.ram_addr];
        for (int b = 0; b < 4; b++)
            if (bus1.ram_wea[b]) mem1[bus1.ram_addr][8*b +: 8] <= bus1.ram_din[8*b +: 8];
    end

    always @(posedge clk) begin
        rd3a <= mem3[bus3.ram_addr];
        rd3b <= rd3a;
        rd3c <= rd3b;
        for (int b = 0; b < 4; b++)
            if (bus3.ram_wea[b]) mem3[bus3.ram_addr][8*b +: 8] <= bus3.ram_din[8*b +: 8];
    end

    assign bus1.ram_dout = rd1;
    assign bus3.ram_dout = rd3c;

    function automatic int mkey(input int b, input logic [31:0] adr);
        return b * 65536 + int'(adr[c_addr_w+1:2]);
    endfunction

    function automatic logic [31:0] model_rd(input int b, input logic [31:0] adr);
        int k = mkey(b, adr);
        return model.exists(k) ? model[k] : 32'h0;
    endfunction

    task automatic model_write(input int b, input logic [3:0] sel, input logic [31:0] adr,
                               input logic [31:0] dat);
        logic [31:0] w;
        w = model_rd(b, adr);
        for (int i = 0; i < 4; i++)
            if (sel[i]) w[8*i +: 8] = dat[8*i +: 8];
        model[mkey(b, adr)] = w;
    endtask

    task automatic drive(input int b, input int m, input logic cyc, input logic stb,
                         input logic we, input logic [3:0] sel, input logic [31:0] adr,
                         input logic [31:0] dat);
        if (b == 1 && m == 0) begin
            bus1.m0_cyc_i = cyc; bus1.m0_stb_i = stb; bus1.m0_we_i = we;
            bus1.m0_sel_i = sel; bus1.m0_adr_i = adr; bus1.m0_dat_i = dat;
        end else if (b == 1) begin
            bus1.m1_cyc_i = cyc; bus1.m1_stb_i = stb; bus1.m1_we_i = we;
            bus1.m1_sel_i = sel; bus1.m1_adr_i = adr; bus1.m1_dat_i = dat;
        end else if (m == 0) begin
            bus3.m0_cyc_i = cyc; bus3.m0_stb_i = stb; bus3.m0_we_i = we;
            bus3.m0_sel_i = sel; bus3.m0_adr_i = adr; bus3.m0_dat_i = dat;
        end else begin
            bus3.m1_cyc_i = cyc; bus3.m1_stb_i = stb; bus3.m1_we_i = we;
            bus3.m1_sel_i = sel; bus3.m1_adr_i = adr; bus3.m1_dat_i = dat;
        end
    endtask

    task automatic idle(input int b);
        drive(b, 0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drive(b, 1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    function automatic logic [1:0] acks(input int b);
        return (b == 1) ? {bus1.m1_ack_o, bus1.m0_ack_o} : {bus3.m1_ack_o, bus3.m0_ack_o};
    endfunction

    function automatic logic [31:0] rdat(input int b, input int m);
        if (b == 1) return (m == 0) ? bus1.m0_dat_o : bus1.m1_dat_o;
        return (m == 0) ? bus3.m0_dat_o : bus3.m1_dat_o;
    endfunction

    task automatic cyc_next();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        cyc_next();
        rst_n = 1'b0;
        cyc_next();
        cyc_next();
        rst_n = 1'b1;
    endtask

    // Single transaction with scoreboard and a bounded wait for the ack.
    task automatic do_txn(input int b, input int m, input logic we, input logic [3:0] sel,
                          input logic [31:0] adr, input logic [31:0] dat);
        exp_t        e;
        logic [1:0]  a;
        logic [31:0] rd;
        bit          got;
        e.who = m[0];
        e.dat = we ? 32'h0 : model_rd(b, adr);
        if (we) model_write(b, sel, adr, dat);
        exp_q.push_back(e);
        drive(b, m, 1'b1, 1'b1, we, sel, adr, dat);
        got = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            @(negedge clk);
            a = acks(b);
            checks++;
            if (a[1-m] !== 1'b0) begin
                errors++;
                $display("FAIL txn_other_ack bus%0d m%0d got %b required 0", b, m, a[1-m]);
            end
            if (a[m] === 1'b1) begin
                e  = exp_q.pop_front();
                rd = rdat(b, m);
                checks++;
                if (rd !== e.dat) begin
                    errors++;
                    $display("FAIL txn_data bus%0d m%0d adr %h got %h required %h", b, m, adr, rd, e.dat);
                end
                got = 1'b1;
            end else begin
                cyc_next();
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL txn_timeout bus%0d m%0d adr %h got no ack required ack", b, m, adr);
            void'(exp_q.pop_back());
        end
        cyc_next();
        idle(b);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({bus1.gnt_o, bus1.ram_wea, bus1.ram_addr, bus1.ram_din, bus1.m0_ack_o, bus1.m1_ack_o,
             bus1.m0_dat_o, bus1.m1_dat_o} !== '0) begin
            errors++;
            $display("FAIL reset_bus1 gnt %b wea %h addr %h din %h required all zero",
                     bus1.gnt_o, bus1.ram_wea, bus1.ram_addr, bus1.ram_din);
        end
        checks++;
        if ({bus3.gnt_o, bus3.ram_wea, bus3.ram_addr, bus3.ram_din, bus3.m0_ack_o, bus3.m1_ack_o} !== '0) begin
            errors++;
            $display("FAIL reset_bus3 gnt %b wea %h addr %h required all zero",
                     bus3.gnt_o, bus3.ram_wea, bus3.ram_addr);
        end
        cyc_next();
        rst_n = 1'b1;
    endtask

    task automatic test_write();
        exp_t e;
        drive(1, 0, 1'b1, 1'b1, 1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF);
        model_write(1, 4'hF, 32'h10, 32'hDEAD_BEEF);
        exp_q.push_back('{who: 1'b0, dat: 32'h0});
        @(negedge clk);
        checks++;
        if (acks(1) !== 2'b00) begin errors++; $display("FAIL wr_t0_ack got %b required 00", acks(1)); end
        cyc_next(); @(negedge clk);
        checks++;
        if ({bus1.ram_wea, bus1.ram_addr, bus1.ram_din, bus1.gnt_o} !== {4'hF, 16'h0004, 32'hDEAD_BEEF, 2'b01}) begin
            errors++;
            $display("FAIL wr_access wea %h addr %h din %h gnt %b required f 0004 deadbeef 01",
                     bus1.ram_wea, bus1.ram_addr, bus1.ram_din, bus1.gnt_o);
        end
        checks++;
        if (acks(1) !== 2'b00) begin errors++; $display("FAIL wr_t1_ack got %b required 00", acks(1)); end
        cyc_next(); @(negedge clk);
        checks++;
        if (acks(1) !== 2'b01) begin errors++; $display("FAIL wr_t2_ack got %b required 01", acks(1)); end
        e = exp_q.pop_front();
        checks++;
        if (bus1.m0_dat_o !== e.dat) begin errors++; $display("FAIL wr_dat got %h required %h", bus1.m0_dat_o, e.dat); end
        checks++;
        if (bus1.ram_wea !== 4'h0) begin errors++; $display("FAIL wr_wea_in_ack got %h required 0", bus1.ram_wea); end
        cyc_next(); idle(1); @(negedge clk);
        checks++;
        if ({acks(1), bus1.gnt_o} !== 4'b0000) begin
            errors++; $display("FAIL wr_t3 ack %b gnt %b required 00 00", acks(1), bus1.gnt_o);
        end
        cyc_next();
    endtask

    task automatic test_read_lat1();
        exp_t e;
        do_txn(1, 0, 1'b1, 4'hF, 32'h8, 32'h1234_5678);
        drive(1, 1, 1'b1, 1'b1, 1'b0, 4'hF, 32'h8, 32'h0);
        exp_q.push_back('{who: 1'b1, dat: model_rd(1, 32'h8)});
        @(negedge clk);
        cyc_next(); @(negedge clk);
        checks++;
        if (bus1.gnt_o !== 2'b10) begin errors++; $display("FAIL rd1_gnt_t1 got %b required 10", bus1.gnt_o); end
        cyc_next(); @(negedge clk);
        checks++;
        if ({bus1.gnt_o, acks(1)} !== 4'b1010) begin
            errors++; $display("FAIL rd1_t2 gnt %b ack %b required 10 10", bus1.gnt_o, acks(1));
        end
        e = exp_q.pop_front();
        checks++;
        if (bus1.m1_dat_o !== e.dat) begin errors++; $display("FAIL rd1_dat got %h required %h", bus1.m1_dat_o, e.dat); end
        checks++;
        if (bus1.m0_dat_o !== 32'h0) begin errors++; $display("FAIL rd1_other_dat got %h required 0", bus1.m0_dat_o); end
        cyc_next(); idle(1);
    endtask

    task automatic test_wrap();
        exp_t e;
        drive(1, 0, 1'b1, 1'b1, 1'b1, 4'b0011, 32'h0004_0010, 32'hAAAA_5555);
        model_write(1, 4'b0011, 32'h0004_0010, 32'hAAAA_5555);
        exp_q.push_back('{who: 1'b0, dat: 32'h0});
        @(negedge clk);
        cyc_next(); @(negedge clk);
        checks++;
        if ({bus1.ram_addr, bus1.ram_wea} !== {16'h0004, 4'b0011}) begin
            errors++; $display("FAIL wrap_access addr %h wea %b required 0004 0011", bus1.ram_addr, bus1.ram_wea);
        end
        cyc_next(); @(negedge clk);
        checks++;
        if (acks(1) !== 2'b01) begin errors++; $display("FAIL wrap_ack got %b required 01", acks(1)); end
        e = exp_q.pop_front();
        cyc_next(); idle(1);
        do_txn(1, 0, 1'b0, 4'hF, 32'h10, 32'h0);
    endtask

    task automatic test_stb_drop();
        exp_t e;
        drive(1, 0, 1'b1, 1'b1, 1'b1, 4'hF, 32'h50, 32'h5A5A_1234);
        model_write(1, 4'hF, 32'h50, 32'h5A5A_1234);
        exp_q.push_back('{who: 1'b0, dat: 32'h0});
        @(negedge clk);
        cyc_next();
        drive(1, 0, 1'b1, 1'b0, 1'b1, 4'hF, 32'h50, 32'h5A5A_1234);
        @(negedge clk);
        checks++;
        if (bus1.ram_wea !== 4'hF) begin errors++; $display("FAIL stb_drop_wea got %h required f", bus1.ram_wea); end
        cyc_next(); @(negedge clk);
        checks++;
        if (acks(1) !== 2'b01) begin errors++; $display("FAIL stb_drop_ack got %b required 01", acks(1)); end
        e = exp_q.pop_front();
        cyc_next(); idle(1);
        do_txn(1, 0, 1'b0, 4'hF, 32'h50, 32'h0);
    endtask

    task automatic test_abort_access();
        drive(1, 0, 1'b1, 1'b1, 1'b1, 4'hF, 32'h30, 32'h1111_1111);
        @(negedge clk);
        cyc_next();
        idle(1);
        @(negedge clk);
        checks++;
        if (bus1.ram_wea !== 4'h0) begin errors++; $display("FAIL abort_acc_wea got %h required 0", bus1.ram_wea); end
        cyc_next(); @(negedge clk);
        checks++;
        if ({bus1.gnt_o, acks(1)} !== 4'b0000) begin
            errors++; $display("FAIL abort_acc_idle gnt %b ack %b required 00 00", bus1.gnt_o, acks(1));
        end
        cyc_next();
    endtask

    task automatic test_read_lat3();
        exp_t e;
        do_txn(3, 0, 1'b1, 4'hF, 32'h40, 32'hCAFE_F00D);
        drive(3, 0, 1'b1, 1'b1, 1'b0, 4'hF, 32'h40, 32'h0);
        exp_q.push_back('{who: 1'b0, dat: model_rd(3, 32'h40)});
        @(negedge clk);
        for (int k = 1; k <= 4; k++) begin
            cyc_next(); @(negedge clk);
            checks++;
            if (bus3.ram_addr !== 16'h0010) begin
                errors++; $display("FAIL rd3_addr t%0d got %h required 0010", k, bus3.ram_addr);
            end
            checks++;
            if (acks(3) !== ((k == 4) ? 2'b01 : 2'b00)) begin
                errors++; $display("FAIL rd3_ack t%0d got %b required %b", k, acks(3), (k == 4) ? 2'b01 : 2'b00);
            end
            if (k == 4) begin
                e = exp_q.pop_front();
                checks++;
                if (bus3.m0_dat_o !== e.dat) begin errors++; $display("FAIL rd3_dat got %h required %h", bus3.m0_dat_o, e.dat); end
            end
        end
        cyc_next(); idle(3); @(negedge clk);
        checks++;
        if (acks(3) !== 2'b00) begin errors++; $display("FAIL rd3_t5_ack got %b required 00", acks(3)); end
        cyc_next();
    endtask

    task automatic test_abort_wait();
        exp_t e;
        bit   got;
        do_txn(3, 0, 1'b1, 4'hF, 32'h8, 32'h0BAD_F00D);
        drive(3, 0, 1'b1, 1'b1, 1'b0, 4'hF, 32'h40, 32'h0);
        @(negedge clk);
        cyc_next(); @(negedge clk);
        checks++;
        if (bus3.gnt_o !== 2'b01) begin errors++; $display("FAIL abw_gnt_access got %b required 01", bus3.gnt_o); end
        cyc_next();
        drive(3, 0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drive(3, 1, 1'b1, 1'b1, 1'b0, 4'hF, 32'h8, 32'h0);
        exp_q.push_back('{who: 1'b1, dat: model_rd(3, 32'h8)});
        @(negedge clk);
        checks++;
        if (acks(3) !== 2'b00) begin errors++; $display("FAIL abw_wait_ack got %b required 00", acks(3)); end
        cyc_next(); @(negedge clk);
        checks++;
        if ({bus3.gnt_o, acks(3)} !== 4'b0000) begin
            errors++; $display("FAIL abw_idle gnt %b ack %b required 00 00", bus3.gnt_o, acks(3));
        end
        cyc_next(); @(negedge clk);
        checks++;
        if (bus3.gnt_o !== 2'b10) begin errors++; $display("FAIL abw_m1_gnt got %b required 10", bus3.gnt_o); end
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            cyc_next(); @(negedge clk);
            checks++;
            if (bus3.m0_ack_o !== 1'b0) begin errors++; $display("FAIL abw_m0_ack got %b required 0", bus3.m0_ack_o); end
            if (bus3.m1_ack_o === 1'b1) begin
                e = exp_q.pop_front();
                checks++;
                if (bus3.m1_dat_o !== e.dat) begin errors++; $display("FAIL abw_m1_dat got %h required %h", bus3.m1_dat_o, e.dat); end
                got = 1'b1;
            end
        end
        checks++;
        if (!got) begin errors++; $display("FAIL abw_timeout got no m1 ack required ack"); void'(exp_q.pop_back()); end
        cyc_next(); idle(3);
    endtask

    task automatic test_reset_mid();
        exp_t e;
        bit   got;
        drive(1, 1, 1'b1, 1'b1, 1'b1, 4'hF, 32'h20, 32'h7777_7777);
        @(negedge clk);
        cyc_next(); @(negedge clk);
        checks++;
        if (bus1.ram_wea !== 4'hF) begin errors++; $display("FAIL rstmid_pre_wea got %h required f", bus1.ram_wea); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus1.ram_wea, acks(1), bus1.gnt_o, bus1.ram_addr} !== '0) begin
            errors++; $display("FAIL rstmid_clear wea %h ack %b gnt %b addr %h required all zero",
                               bus1.ram_wea, acks(1), bus1.gnt_o, bus1.ram_addr);
        end
        cyc_next(); cyc_next();
        rst_n = 1'b1;
        drive(1, 0, 1'b1, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
        drive(1, 1, 1'b1, 1'b1, 1'b0, 4'hF, 32'h8, 32'h0);
        exp_q.push_back('{who: 1'b0, dat: model_rd(1, 32'h10)});
        cyc_next(); @(negedge clk);
        checks++;
        if (bus1.gnt_o !== 2'b01) begin errors++; $display("FAIL rstmid_first_gnt got %b required 01", bus1.gnt_o); end
        got = 1'b0;
        for (int i = 0; i < 6 && !got; i++) begin
            cyc_next(); @(negedge clk);
            if (acks(1) !== 2'b00) begin
                e = exp_q.pop_front();
                checks++;
                if ({acks(1), bus1.m0_dat_o} !== {2'b01, e.dat}) begin
                    errors++; $display("FAIL rstmid_ack ack %b dat %h required 01 %h", acks(1), bus1.m0_dat_o, e.dat);
                end
                got = 1'b1;
            end
        end
        checks++;
        if (!got) begin errors++; $display("FAIL rstmid_timeout got no ack required ack"); void'(exp_q.pop_back()); end
        cyc_next(); idle(1);
    endtask

    task automatic test_arbitration();
        exp_t       e;
        logic [1:0] a;
        int         n;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
`ifdef WB_ARB_RR_EN
            e.who = i[0];
`else
            e.who = 1'b0;
`endif
            e.dat = model_rd(1, e.who ? 32'h8 : 32'h10);
            exp_q.push_back(e);
        end
        drive(1, 0, 1'b1, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
        drive(1, 1, 1'b1, 1'b1, 1'b0, 4'hF, 32'h8, 32'h0);
        n = 0;
        for (int c = 0; c < 60 && n < 6; c++) begin
            @(negedge clk);
            a = acks(1);
            if (a !== 2'b00) begin
                e = exp_q.pop_front();
                checks++;
                if (a !== (e.who ? 2'b10 : 2'b01)) begin
                    errors++; $display("FAIL arb_order #%0d got ack %b required %b", n, a, e.who ? 2'b10 : 2'b01);
                end
                checks++;
                if (rdat(1, e.who ? 1 : 0) !== e.dat) begin
                    errors++; $display("FAIL arb_dat #%0d got %h required %h", n, rdat(1, e.who ? 1 : 0), e.dat);
                end
                n++;
            end
            if (n < 6) cyc_next();
        end
        checks++;
        if (n != 6) begin
            errors++; $display("FAIL arb_timeout got %0d acks required 6", n);
            while (exp_q.size() > 0) void'(exp_q.pop_front());
        end
        cyc_next(); idle(1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        idle(1);
        idle(3);
        test_reset();
        test_write();
        test_read_lat1();
        test_wrap();
        test_stb_drop();
        test_abort_access();
        test_read_lat3();
        test_abort_wait();
        test_reset_mid();
        test_arbitration();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_leftover got %0d entries required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_ram_arbiter.md
Name: wb_ram_arbiter

Overview:
- Two-master Wishbone arbiter and sequencer in front of one single-port block RAM.
- Lets the CPU data master (m0) and instruction master (m1) share one BRAM without the full interconnect.
- Arbitrates per transaction, drives the RAM port directly (write enable, address, write data), counts RAM read latency and returns single-cycle acks.
- Sits between the MiniMIPS32 Wishbone masters and a blk_mem_gen instance.

Parameters:
ADDR_W, 16, word-address width driven to the RAM (byte address bits [ADDR_W+1:2])
RD_LAT, 1, RAM read latency in cycles; legal range 1..3

Ports:
clk_i  in  1  system clock; all logic on the rising edge
rst_i  in  1  reset, asynchronous, active-low
m0_cyc_i  in  1  master 0 cycle
m0_stb_i  in  1  master 0 strobe
m0_we_i  in  1  master 0 write
m0_sel_i  in  4  master 0 byte selects
m0_adr_i  in  32  master 0 byte address
m0_dat_i  in  32  master 0 write data
m0_dat_o  out  32  master 0 read data
m0_ack_o  out  1  master 0 ack
m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i, m1_dat_o, m1_ack_o: same as m0, for master 1
ram_wea  out  4  RAM byte write enables
ram_addr  out  ADDR_W  RAM word address
ram_din  out  32  RAM write data
ram_dout  in  32  RAM read data
gnt_o  out  2  one-hot current grant, status only

Behaviour:
- Interface: one clock, clk_i. Reset rst_i is asynchronous and active-low.
- Request: req_n = mN_cyc_i & mN_stb_i.
- Reset values: state IDLE; gnt_o=00; ram_wea=0; ram_addr=0; ram_din=0; m0/m1_ack_o=0; m0/m1_dat_o=0; last-grant register=m1.
- Reset asserted mid-transaction: all outputs clear immediately. No ack is issued for the aborted transfer.
- FSM states: IDLE, ACCESS, WAIT, ACK.
- IDLE:
  - If any req_n is high, select a winner and register gnt_o; go to ACCESS.
  - Otherwise stay in IDLE.
  - gnt_o=00 while in IDLE.
- ACCESS (one cycle):
  - ram_addr = granted adr[ADDR_W+1:2]; ram_din = granted dat_i.
  - ram_wea = granted sel_i if we_i, else 0000.
  - Write: go to ACK.
  - Read with RD_LAT=1: go to ACK.
  - Read with RD_LAT>1: go to WAIT with counter = RD_LAT-1.
- WAIT:
  - Decrement the counter each cycle; ram_addr is held.
  - Go to ACK when the counter reaches 1.
- ACK (one cycle):
  - Granted mN_ack_o=1.
  - Granted mN_dat_o = ram_dout on reads; 0 on writes.
  - Update the last-grant register; go to IDLE.
- Latency, request first seen in IDLE at cycle T:
  - Write: ACCESS at T+1, ack at T+2.
  - Read: ack at T+1+RD_LAT.
  - Minimum one IDLE cycle between back-to-back transactions.
- Ack rules:
  - Ack is always exactly one cycle, only to the granted master.
  - The non-granted master sees ack=0 and dat_o=0.
  - ram_wea is nonzero only in ACCESS.
- Abort: the granted master dropping cyc_i before its ack gives the following.
  - In ACCESS: ram_wea forced 0000.
  - In any state: no ack; return to IDLE next cycle; last-grant register unchanged.
- Dropping stb_i while cyc_i stays high does not abort; the transaction completes.
- Address bits above ADDR_W+1 are ignored, so addresses wrap modulo the RAM size.
- Both masters requesting in the same IDLE cycle: resolved by the arbitration policy below.
- Requests arriving outside IDLE wait; they are not lost while held.

Optional Feature:
- Macro: WB_ARB_RR_EN.
- Defined: round-robin. On a tie the master not in the last-grant register wins. First tie after reset goes to m0.
- Undefined: fixed priority. m0 always wins ties; m1 is served only when m0 is idle. The last-grant register is still maintained but unused.

Test Plan:
1. m0 write adr=0x0000_0010, dat=0xDEADBEEF, sel=1111 at T:
   - T+1: ram_wea=1111, ram_addr=0x0004, ram_din=0xDEADBEEF.
   - T+2: m0_ack_o=1, one cycle only.
   - m1_ack_o stays 0 throughout.
2. RAM word 2 = 0x12345678, RD_LAT=1; m1 read adr=0x8 at T:
   - T+2: m1_ack_o=1, m1_dat_o=0x12345678.
   - gnt_o=10 during T+1..T+2.
3. RD_LAT=3, m0 read at T:
   - ack at T+4 only; ram_addr stable T+1..T+4.
4. Both masters hold continuous reads for 6 transactions:
   - With WB_ARB_RR_EN: grant order m0,m1,m0,m1,m0,m1.
   - Without it: six m0 grants, m1 ack never asserted.
5. RD_LAT=3; m0 read granted, m0_cyc_i dropped in WAIT while m1 requests:
   - No m0 ack; IDLE next cycle; m1 granted the cycle after.
6. rst_i driven low during an m1 write ACCESS:
   - ram_wea=0000 and acks 0 immediately.
   - After release, both request: m0 granted first.
